// File: rtl/psum_accumulator_pkg.sv
// Shared types and constants for the partial-sum accumulator: FSM states,
// IEEE-754 single-precision constants and FP_Adder mode/rounding encodings.
package psum_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    ADD  = 2'd2,
    EMIT = 2'd3
  } psum_state_e;

  localparam logic [31:0] FP_ZERO  = 32'h0000_0000;
  localparam int          SIGN_BIT = 31;

  localparam logic       MODE_ADD  = 1'b0;
  localparam logic       MODE_SUB  = 1'b1;

  localparam logic [1:0] RMODE_RNE = 2'b00;
  localparam logic [1:0] RMODE_RTZ = 2'b01;
  localparam logic [1:0] RMODE_RUP = 2'b10;
  localparam logic [1:0] RMODE_RDN = 2'b11;

  function automatic logic [31:0] fp_relu(input logic [31:0] v);
    return v[SIGN_BIT] ? FP_ZERO : v;
  endfunction

endpackage

// File: rtl/FP_Adder.sv
// Two-stage IEEE-754 single-precision adder: align, then add/normalise/round.
// Subnormal inputs and results flush to zero; infinities pass through.
module FP_Adder
  import psum_accumulator_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Valid_In,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Mode,
  input  logic [1:0]  RMode,
  output logic        Valid_Out,
  output logic [31:0] Result
);

  function automatic logic round_inc(input logic [1:0] rm, input logic sign,
                                     input logic lsb, input logic g,
                                     input logic r, input logic s);
    case (rm)
      RMODE_RNE: return g & (r | s | lsb);
      RMODE_RTZ: return 1'b0;
      RMODE_RUP: return ~sign & (g | r | s);
      default:   return sign & (g | r | s);
    endcase
  endfunction

  function automatic logic [31:0] round_pack(input logic sign,
                                             input logic signed [9:0] exp_in,
                                             input logic [26:0] norm,
                                             input logic [1:0] rm);
    logic [24:0]       mr;
    logic signed [9:0] e;
    mr = {1'b0, norm[26:3]} + 25'(round_inc(rm, sign, norm[3], norm[2], norm[1], norm[0]));
    e  = exp_in;
    if (mr[24]) begin
      mr = mr >> 1;
      e  = e + 10'sd1;
    end
    if (e <= 10'sd0)        return {sign, 31'd0};
    else if (e >= 10'sd255) return {sign, 8'hFF, 23'd0};
    else                    return {sign, e[7:0], mr[22:0]};
  endfunction

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(26 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  // ---- stage p0: unpack, order by magnitude, align the smaller operand
  logic        sa_p0, sb_p0, sl_p0, ss_p0, swap_p0, spec_p0;
  logic [7:0]  ea_p0, eb_p0, el_p0, es_p0, diff_p0;
  logic [23:0] ma_p0, mb_p0, ml_p0, ms_p0;
  logic [4:0]  sh_p0;
  logic [55:0] shf_p0;
  logic [26:0] al_p0;
  logic [31:0] spec_val_p0;

  always_comb begin
    sa_p0   = A[31];
    sb_p0   = B[31] ^ (Mode == MODE_SUB);
    ea_p0   = A[30:23];
    eb_p0   = B[30:23];
    ma_p0   = (ea_p0 == 8'd0) ? 24'd0 : {1'b1, A[22:0]};
    mb_p0   = (eb_p0 == 8'd0) ? 24'd0 : {1'b1, B[22:0]};
    swap_p0 = {eb_p0, mb_p0} > {ea_p0, ma_p0};
    sl_p0   = swap_p0 ? sb_p0 : sa_p0;
    ss_p0   = swap_p0 ? sa_p0 : sb_p0;
    el_p0   = swap_p0 ? eb_p0 : ea_p0;
    es_p0   = swap_p0 ? ea_p0 : eb_p0;
    ml_p0   = swap_p0 ? mb_p0 : ma_p0;
    ms_p0   = swap_p0 ? ma_p0 : mb_p0;
    diff_p0 = el_p0 - es_p0;
    sh_p0   = (diff_p0 > 8'd31) ? 5'd31 : diff_p0[4:0];
    shf_p0  = {ms_p0, 32'd0} >> sh_p0;
    al_p0   = {shf_p0[55:30], shf_p0[29] | (|shf_p0[28:0])};
    spec_p0 = (ea_p0 == 8'hFF) || (eb_p0 == 8'hFF);
    spec_val_p0 = (ea_p0 == 8'hFF) ? {sa_p0, A[30:0]} : {sb_p0, B[30:0]};
  end

  logic        vld_p1_q, vld_out_q;
  logic        sign_p1_q, sub_p1_q, spec_p1_q;
  logic [7:0]  exp_p1_q;
  logic [26:0] ml_p1_q, ms_p1_q;
  logic [1:0]  rmode_p1_q;
  logic [31:0] spec_val_p1_q, result_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q  <= 1'b0;
      vld_out_q <= 1'b0;
    end else begin
      vld_p1_q  <= Valid_In;
      vld_out_q <= vld_p1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (Valid_In) begin
      sign_p1_q     <= sl_p0;
      sub_p1_q      <= sl_p0 ^ ss_p0;
      exp_p1_q      <= el_p0;
      ml_p1_q       <= {ml_p0, 3'b000};
      ms_p1_q       <= al_p0;
      rmode_p1_q    <= RMode;
      spec_p1_q     <= spec_p0;
      spec_val_p1_q <= spec_val_p0;
    end
  end

  // ---- stage p1: magnitude add/subtract, normalise, round and pack
  logic [27:0]       sum_p1;
  logic [26:0]       norm_p1;
  logic [4:0]        lz_p1;
  logic signed [9:0] exp_n_p1;
  logic [31:0]       res_p1;

  always_comb begin
    sum_p1 = sub_p1_q ? ({1'b0, ml_p1_q} - {1'b0, ms_p1_q})
                      : ({1'b0, ml_p1_q} + {1'b0, ms_p1_q});
    lz_p1  = lzc27(sum_p1[26:0]);
    if (sum_p1[27]) begin
      norm_p1  = {sum_p1[27:2], sum_p1[1] | sum_p1[0]};
      exp_n_p1 = $signed({2'b00, exp_p1_q}) + 10'sd1;
    end else begin
      norm_p1  = sum_p1[26:0] << lz_p1;
      exp_n_p1 = $signed({2'b00, exp_p1_q}) - $signed({5'b00000, lz_p1});
    end
    res_p1 = round_pack(sign_p1_q, exp_n_p1, norm_p1, rmode_p1_q);
    // An exact cancellation is +0 except when rounding toward -inf.
    if (sum_p1 == 28'd0)
      res_p1 = {sub_p1_q ? (rmode_p1_q == RMODE_RDN) : sign_p1_q, 31'd0};
    if (spec_p1_q) res_p1 = spec_val_p1_q;
  end

  always_ff @(posedge clk) begin
    if (vld_p1_q) result_q <= res_p1;
  end

  assign Valid_Out = vld_out_q;
  assign Result    = result_q;

endmodule

// File: rtl/psum_fifo.sv
// Show-ahead FIFO holding {Last, Data} entries; ready is registered and
// derived from the next-state count so a full FIFO never accepts an entry.
module psum_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             ready_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ready_q, ready_d;
  logic             do_push, do_pop;

  assign do_push = push_i && ready_q;
  assign do_pop  = pop_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ready_d = (count_d != CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign ready_o = ready_q;

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates FP32 partial-sum groups (terminated by Last_In) through FP_Adder.
// Define PSUM_RELU_EN to clamp negative group results to +0 on output.
module psum_accumulator
  import psum_accumulator_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Data_In,
  input  logic        Valid_In,
  input  logic        Last_In,
  output logic        Ready_Out,
  output logic [31:0] Data_Out,
  output logic        Valid_Out,
  output logic        Drop_Err
);

  function automatic logic [31:0] emit_value(input logic [31:0] acc);
`ifdef PSUM_RELU_EN
    return fp_relu(acc);
`else
    return acc;
`endif
  endfunction

  psum_state_e state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] data_out_q, data_out_d;
  logic        last_q, last_d;
  logic        valid_out_q, valid_out_d;
  logic        drop_q, drop_d;

  logic        fifo_empty, fifo_ready, pop;
  logic [32:0] fifo_rdata;
  logic [31:0] head_data;
  logic        head_last;
  logic        add_vld, add_vout;
  logic [31:0] add_sum;

  psum_fifo #(.DEPTH(DEPTH), .WIDTH(33)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (Valid_In),
    .wdata_i ({Last_In, Data_In}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .ready_o (fifo_ready)
  );

  assign head_data = fifo_rdata[31:0];
  assign head_last = fifo_rdata[32];

  FP_Adder u_adder (
    .clk       (clk),
    .rst_n     (rst_n),
    .Valid_In  (add_vld),
    .A         (acc_q),
    .B         (head_data),
    .Mode      (MODE_ADD),
    .RMode     (RMODE_RNE),
    .Valid_Out (add_vout),
    .Result    (add_sum)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    last_d      = last_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    pop         = 1'b0;
    add_vld     = 1'b0;
    drop_d      = drop_q | (Valid_In & ~fifo_ready);
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          acc_d   = head_data;
          state_d = head_last ? EMIT : HOLD;
        end
      end
      HOLD: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          add_vld = 1'b1;
          last_d  = head_last;
          state_d = ADD;
        end
      end
      ADD: begin
        // Waits on the adder handshake so any adder latency works.
        if (add_vout) begin
          acc_d   = add_sum;
          state_d = last_q ? EMIT : HOLD;
        end
      end
      EMIT: begin
        data_out_d  = emit_value(acc_q);
        valid_out_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= FP_ZERO;
      last_q      <= 1'b0;
      data_out_q  <= FP_ZERO;
      valid_out_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      last_q      <= last_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      drop_q      <= drop_d;
    end
  end

  assign Ready_Out = fifo_ready;
  assign Data_Out  = data_out_q;
  assign Valid_Out = valid_out_q;
  assign Drop_Err  = drop_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: a table of accumulation groups plus
// hand-written sequences for latency, overflow/drop, reset mid-add and back-to-back groups.
`timescale 1ns/1ps
module tb_psum_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] Data_In = '0;
  logic        Valid_In = 1'b0;
  logic        Last_In = 1'b0;
  logic        Ready_Out, Valid_Out, Drop_Err;
  logic [31:0] Data_Out;

  int          checks = 0;
  int          errors = 0;
  int          npulse = 0;
  logic [31:0] pdata [8];

`ifdef PSUM_RELU_EN
  localparam logic [31:0] EXP_NEG4  = 32'h0000_0000;
  localparam logic [31:0] EXP_NEG0  = 32'h0000_0000;
`else
  localparam logic [31:0] EXP_NEG4  = 32'hC080_0000;
  localparam logic [31:0] EXP_NEG0  = 32'h8000_0000;
`endif

  typedef struct {
    int          n;
    logic [31:0] d0, d1, d2;
    logic [31:0] expv;
  } vec_t;

  vec_t tbl [9];

  always #5 clk = ~clk;

  psum_accumulator #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Data_In   (Data_In),
    .Valid_In  (Valid_In),
    .Last_In   (Last_In),
    .Ready_Out (Ready_Out),
    .Data_Out  (Data_Out),
    .Valid_Out (Valid_Out),
    .Drop_Err  (Drop_Err)
  );

  always @(negedge clk) begin
    if (rst_n && Valid_Out) begin
      if (npulse < 8) pdata[npulse] = Data_Out;
      npulse = npulse + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic push(input logic [31:0] d, input logic l);
    Valid_In = 1'b1;
    Data_In  = d;
    Last_In  = l;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    Valid_In = 1'b0;
    Last_In  = 1'b0;
    Data_In  = '0;
  endtask

  task automatic wait_pulses(input int want, input int budget);
    for (int k = 0; k < budget && npulse < want; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    tbl[0] = '{1, 32'h3F80_0000, 32'h0,         32'h0,         32'h3F80_0000};
    tbl[1] = '{3, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000};
    tbl[2] = '{2, 32'h3F80_0000, 32'hC0A0_0000, 32'h0,         EXP_NEG4};
    tbl[3] = '{2, 32'h4000_0000, 32'h3F00_0000, 32'h0,         32'h4020_0000};
    tbl[4] = '{2, 32'h3F80_0000, 32'hBF80_0000, 32'h0,         32'h0000_0000};
    tbl[5] = '{1, 32'h8000_0000, 32'h0,         32'h0,         EXP_NEG0};
    tbl[6] = '{2, 32'h3F80_0000, 32'h3380_0000, 32'h0,         32'h3F80_0000};
    tbl[7] = '{2, 32'h3F80_0001, 32'h3380_0000, 32'h0,         32'h3F80_0002};
    tbl[8] = '{3, 32'hC040_0000, 32'h4080_0000, 32'hBF00_0000, 32'h3F00_0000};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst Ready_Out", {31'd0, Ready_Out}, 32'd1);
    check("rst Valid_Out", {31'd0, Valid_Out}, 32'd0);
    check("rst Data_Out", Data_Out, 32'h0);
    check("rst Drop_Err", {31'd0, Drop_Err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table of groups
    for (int i = 0; i < 9; i++) begin
      logic [31:0] d;
      npulse = 0;
      for (int j = 0; j < tbl[i].n; j++) begin
        d = (j == 0) ? tbl[i].d0 : (j == 1) ? tbl[i].d1 : tbl[i].d2;
        push(d, (j == tbl[i].n - 1));
      end
      idle_in();
      wait_pulses(1, 60);
      repeat (6) @(posedge clk);
      #1;
      check($sformatf("vec%0d pulses", i), 32'(npulse), 32'd1);
      check($sformatf("vec%0d data", i), pdata[0], tbl[i].expv);
    end
    check("table Drop_Err", {31'd0, Drop_Err}, 32'd0);

    // One-entry group latency: pulse visible after the second edge past the push
    npulse = 0;
    Valid_In = 1'b1;
    Data_In  = 32'h3F80_0000;
    Last_In  = 1'b1;
    @(posedge clk);
    #1;
    idle_in();
    @(negedge clk);
    check("lat cyc0 Valid_Out", {31'd0, Valid_Out}, 32'd0);
    @(negedge clk);
    check("lat cyc1 Valid_Out", {31'd0, Valid_Out}, 32'd0);
    @(negedge clk);
    check("lat cyc2 Valid_Out", {31'd0, Valid_Out}, 32'd1);
    check("lat cyc2 Data_Out", Data_Out, 32'h3F80_0000);
    @(negedge clk);
    check("lat cyc3 Valid_Out", {31'd0, Valid_Out}, 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back one-entry groups
    npulse = 0;
    push(32'h3F80_0000, 1'b1);
    push(32'h4000_0000, 1'b1);
    idle_in();
    wait_pulses(2, 60);
    repeat (6) @(posedge clk);
    #1;
    check("b2b pulses", 32'(npulse), 32'd2);
    check("b2b first", pdata[0], 32'h3F80_0000);
    check("b2b second", pdata[1], 32'h4000_0000);

    // Overflow: 9 back-to-back pushes, the 8th and 9th land while full
    npulse = 0;
    for (int j = 0; j < 9; j++) begin
      logic [31:0] d;
      d = 32'h3F80_0000 + (32'(j) << 23);
      push(d, (j >= 6));
      if (j == 5) check("ovf ready after 6", {31'd0, Ready_Out}, 32'd1);
      if (j == 6) begin
        check("ovf ready after 7", {31'd0, Ready_Out}, 32'd0);
        check("ovf drop after 7", {31'd0, Drop_Err}, 32'd0);
      end
      if (j == 7) begin
        check("ovf drop after 8", {31'd0, Drop_Err}, 32'd1);
        check("ovf ready after 8", {31'd0, Ready_Out}, 32'd0);
      end
    end
    idle_in();
    wait_pulses(1, 80);
    repeat (8) @(posedge clk);
    #1;
    check("ovf pulses", 32'(npulse), 32'd1);
    check("ovf sum", pdata[0], 32'h42FE_0000);
    check("ovf ready recovered", {31'd0, Ready_Out}, 32'd1);
    check("ovf drop sticky", {31'd0, Drop_Err}, 32'd1);

    // Reset while the group {1.0, 2.0} is in ADD
    npulse = 0;
    push(32'h3F80_0000, 1'b0);
    push(32'h4000_0000, 1'b1);
    idle_in();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst Valid_Out", {31'd0, Valid_Out}, 32'd0);
    check("midrst Data_Out", Data_Out, 32'h0);
    check("midrst Drop_Err", {31'd0, Drop_Err}, 32'd0);
    check("midrst Ready_Out", {31'd0, Ready_Out}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (10) @(posedge clk);
    #1;
    check("midrst no pulse", 32'(npulse), 32'd0);
    push(32'h4040_0000, 1'b1);
    idle_in();
    wait_pulses(1, 60);
    repeat (6) @(posedge clk);
    #1;
    check("post-rst pulses", 32'(npulse), 32'd1);
    check("post-rst data", pdata[0], 32'h4040_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
